// File: rtl/audio_pkg.sv
// Shared constants, state encoding and saturation for the audio mixer.
// MIXER_DC_BLOCK_EN adds the DC state used by the optional DC-blocking filter.
package audio_pkg;

  localparam int ACC_W     = 18;
  localparam int BEEP_SPK  = 8192;
  localparam int BEEP_EAR  = 4096;
  localparam int BEEP_MIC  = 2048;
  localparam int AY_SHIFT  = 6;
  localparam int DC_OFFSET = -16384;
  localparam int DC_SHIFT  = 8;

  typedef enum logic [2:0] {
    IDLE,
    S0,
    S1,
    S2,
    S3,
`ifdef MIXER_DC_BLOCK_EN
    SAT,
    DC
`else
    SAT
`endif
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -32768;

  function automatic logic signed [15:0] sat16(
    input logic signed [ACC_W-1:0] x
  );
    if (x > SAT_MAX)
      return 16'sh7FFF;
    else if (x < SAT_MIN)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction

endpackage

// File: rtl/audio_mixer_if.sv
// Sample-side signal bundle of the audio mixer, used by the
// driving environment; clock and reset stay outside.
interface audio_mixer_if;
  import audio_pkg::*;

  logic              ce;
  logic              spk;
  logic              ear;
  logic              mic;
  logic [7:0]        a;
  logic [7:0]        b;
  logic [7:0]        c;
  logic              stereo;
  logic signed [15:0] l;
  logic signed [15:0] r;
  logic              valid;

  modport master (
    output ce, spk, ear, mic,
    output a, b, c, stereo,
    input  l, r, valid
  );

  modport slave (
    input  ce, spk, ear, mic,
    input  a, b, c, stereo,
    output l, r, valid
  );

endinterface

// File: rtl/mixer_dc_block.sv
// One-pole DC-blocking filter: out = sat - avg, avg tracks the
// input with a 2^-DC_SHIFT leak. Used only with MIXER_DC_BLOCK_EN.
module mixer_dc_block
  import audio_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               i_en,
  input  logic signed [15:0] i_sat,
  output logic signed [15:0] o_out
);

  logic signed [15:0]      r_avg;
  logic signed [ACC_W-1:0] w_diff;
  logic signed [ACC_W-1:0] w_step;

  assign w_diff = $signed({{2{i_sat[15]}}, i_sat})
                - $signed({{2{r_avg[15]}}, r_avg});
  assign w_step = w_diff >>> DC_SHIFT;
  assign o_out  = sat16(w_diff);

  always_ff @(posedge clock) begin
    if (reset)
      r_avg <= '0;
    else if (i_en)
      r_avg <= r_avg + w_step[15:0];
  end

endmodule

// File: rtl/audio_mixer.sv
// Beeper + AY three-channel mixer, mono or ACB stereo, 16-bit out.
// Define MIXER_DC_BLOCK_EN for a per-channel DC-blocking stage.
module audio_mixer
  import audio_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               ce,
  input  logic               spk,
  input  logic               ear,
  input  logic               mic,
  input  logic [7:0]         a,
  input  logic [7:0]         b,
  input  logic [7:0]         c,
  input  logic               stereo,
  output logic signed [15:0] l,
  output logic signed [15:0] r,
  output logic               valid
);

  state_t                  r_state;
  logic                    r_spk, r_ear, r_mic, r_stereo;
  logic [7:0]              r_a, r_b, r_c;
  logic signed [ACC_W-1:0] r_acc_l, r_acc_r;

  logic [7:0]       w_lvl;
  logic [ACC_W-1:0] w_full, w_half, w_beep;
  logic [ACC_W-1:0] w_add_l, w_add_r;

  assign w_lvl  = (r_state == S1) ? r_a :
                  (r_state == S2) ? r_b : r_c;
  assign w_full = ACC_W'(w_lvl) << AY_SHIFT;
  assign w_half = w_full >> 1;
  assign w_beep = ACC_W'(r_spk ? BEEP_SPK : 0)
                + ACC_W'(r_ear ? BEEP_EAR : 0)
                + ACC_W'(r_mic ? BEEP_MIC : 0);

  // ACB stereo: A leans left, C leans right, B is centred
  always_comb begin
    w_add_l = '0;
    w_add_r = '0;
    unique case (1'b1)
      (r_state == S0): begin
        w_add_l = w_beep;
        w_add_r = w_beep;
      end
      (r_state == S1): begin
        w_add_l = w_full;
        w_add_r = r_stereo ? w_half : w_full;
      end
      (r_state == S2): begin
        w_add_l = w_full;
        w_add_r = w_full;
      end
      (r_state == S3): begin
        w_add_l = r_stereo ? w_half : w_full;
        w_add_r = w_full;
      end
      default: ;
    endcase
  end

`ifdef MIXER_DC_BLOCK_EN
  logic signed [15:0] r_sat_l, r_sat_r;
  logic signed [15:0] w_dc_l, w_dc_r;
  logic               w_dc_en;

  assign w_dc_en = (r_state == DC);

  mixer_dc_block u_dc_l (
    .clock (clock),
    .reset (reset),
    .i_en  (w_dc_en),
    .i_sat (r_sat_l),
    .o_out (w_dc_l)
  );

  mixer_dc_block u_dc_r (
    .clock (clock),
    .reset (reset),
    .i_en  (w_dc_en),
    .i_sat (r_sat_r),
    .o_out (w_dc_r)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_spk    <= 1'b0;
      r_ear    <= 1'b0;
      r_mic    <= 1'b0;
      r_stereo <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_acc_l  <= '0;
      r_acc_r  <= '0;
      l        <= '0;
      r        <= '0;
      valid    <= 1'b0;
`ifdef MIXER_DC_BLOCK_EN
      r_sat_l  <= '0;
      r_sat_r  <= '0;
`endif
    end else begin
      valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (ce) begin
            r_spk    <= spk;
            r_ear    <= ear;
            r_mic    <= mic;
            r_stereo <= stereo;
            r_a      <= a;
            r_b      <= b;
            r_c      <= c;
            r_acc_l  <= ACC_W'(DC_OFFSET);
            r_acc_r  <= ACC_W'(DC_OFFSET);
            r_state  <= S0;
          end
        end
        S0, S1, S2, S3: begin
          r_acc_l <= r_acc_l + w_add_l;
          r_acc_r <= r_acc_r + w_add_r;
          r_state <= (r_state == S0) ? S1 :
                     (r_state == S1) ? S2 :
                     (r_state == S2) ? S3 : SAT;
        end
`ifdef MIXER_DC_BLOCK_EN
        SAT: begin
          r_sat_l <= sat16(r_acc_l);
          r_sat_r <= sat16(r_acc_r);
          r_state <= DC;
        end
        DC: begin
          l       <= w_dc_l;
          r       <= w_dc_r;
          valid   <= 1'b1;
          r_state <= IDLE;
        end
`else
        SAT: begin
          l       <= sat16(r_acc_l);
          r       <= sat16(r_acc_r);
          valid   <= 1'b1;
          r_state <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer (default build): levels, stereo
// weights, saturation, latency, ce filtering and reset abort.
module tb_audio_mixer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  audio_mixer_if m ();

  audio_mixer dut (
    .clock  (clock),
    .reset  (reset),
    .ce     (m.ce),
    .spk    (m.spk),
    .ear    (m.ear),
    .mic    (m.mic),
    .a      (m.a),
    .b      (m.b),
    .c      (m.c),
    .stereo (m.stereo),
    .l      (m.l),
    .r      (m.r),
    .valid  (m.valid)
  );

  always #5 clock = ~clock;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(
    input logic       i_spk,
    input logic       i_ear,
    input logic       i_mic,
    input logic [7:0] i_a,
    input logic [7:0] i_b,
    input logic [7:0] i_c,
    input logic       i_st
  );
    m.spk    = i_spk;
    m.ear    = i_ear;
    m.mic    = i_mic;
    m.a      = i_a;
    m.b      = i_b;
    m.c      = i_c;
    m.stereo = i_st;
  endtask

  // one sample; inputs are scrambled after the snapshot edge
  task automatic sample(
    input string       tag,
    input logic        i_spk,
    input logic        i_ear,
    input logic        i_mic,
    input logic [7:0]  i_a,
    input logic [7:0]  i_b,
    input logic [7:0]  i_c,
    input logic        i_st,
    input logic [15:0] exp_l,
    input logic [15:0] exp_r
  );
    set_in(i_spk, i_ear, i_mic, i_a, i_b, i_c, i_st);
    m.ce = 1'b1;
    step();
    m.ce = 1'b0;
    set_in(~i_spk, ~i_ear, ~i_mic, ~i_a, ~i_b, ~i_c, ~i_st);
    repeat (4) step();
    check({tag, ".early"}, 16'(m.valid), 16'd0);
    step();
    check({tag, ".valid"}, 16'(m.valid), 16'd1);
    check({tag, ".l"}, m.l, exp_l);
    check({tag, ".r"}, m.r, exp_r);
    step();
    check({tag, ".vdrop"}, 16'(m.valid), 16'd0);
    check({tag, ".lhold"}, m.l, exp_l);
    set_in(0, 0, 0, 8'd0, 8'd0, 8'd0, 0);
  endtask

  initial begin
    m.ce = 1'b0;
    set_in(0, 0, 0, 8'd0, 8'd0, 8'd0, 0);
    reset = 1'b1;
    step();
    step();
    check("rst.l", m.l, 16'h0000);
    check("rst.r", m.r, 16'h0000);
    check("rst.v", 16'(m.valid), 16'd0);
    reset = 1'b0;
    step();

    sample("zero", 0, 0, 0, 8'd0, 8'd0, 8'd0, 0,
           16'hC000, 16'hC000);
    sample("spk", 1, 0, 0, 8'd0, 8'd0, 8'd0, 0,
           16'hE000, 16'hE000);
    sample("maxm", 1, 1, 1, 8'd255, 8'd255, 8'd255, 0,
           16'h7FFF, 16'h7FFF);
    sample("acbA", 0, 0, 0, 8'd255, 8'd0, 8'd0, 1,
           16'hFFC0, 16'hDFE0);
    sample("acbC", 0, 0, 0, 8'd0, 8'd0, 8'd255, 1,
           16'hDFE0, 16'hFFC0);
    sample("acbB", 0, 0, 0, 8'd0, 8'd255, 8'd0, 1,
           16'hFFC0, 16'hFFC0);
    sample("mid", 0, 0, 0, 8'h80, 8'h80, 8'h80, 0,
           16'h2000, 16'h2000);
    sample("ear", 0, 1, 0, 8'h10, 8'd0, 8'd0, 0,
           16'hD400, 16'hD400);
    sample("maxs", 1, 1, 1, 8'd255, 8'd255, 8'd255, 1,
           16'h7FFF, 16'h7FFF);

    // ce at k, k+2 (ignored), k+5 (ignored), k+6 (accepted)
    for (int i = 0; i <= 11; i++) begin
      m.ce  = (i == 0) || (i == 2) || (i == 5) || (i == 6);
      m.spk = (i >= 1);
      step();
      if (i > 0)
        check($sformatf("ceseq.v%0d", i), 16'(m.valid),
              16'((i == 5) || (i == 11)));
      if (i == 5)
        check("ceseq.l1", m.l, 16'hC000);
      if (i == 11)
        check("ceseq.l2", m.l, 16'hE000);
    end
    m.ce  = 1'b0;
    m.spk = 1'b0;
    step();

    // reset at k+3 aborts the sample in flight
    m.ce = 1'b1;
    step();
    m.ce = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort.l", m.l, 16'h0000);
    check("abort.r", m.r, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("abort.v%0d", i), 16'(m.valid), 16'd0);
      step();
    end
    sample("post", 1, 0, 0, 8'd0, 8'd0, 8'd0, 0,
           16'hE000, 16'hE000);

    // reset wins over ce in the same clock
    reset = 1'b1;
    m.ce  = 1'b1;
    step();
    reset = 1'b0;
    m.ce  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rstce.v%0d", i), 16'(m.valid), 16'd0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 SHALL have these ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  sample strobe, one-clock pulse per output sample.
- spk  in  1  beeper bit.
- ear  in  1  tape-in bit.
- mic  in  1  tape-out bit.
- a, b, c  in  8 each  AY channel A/B/C levels, unsigned.
- stereo  in  1  0 = mono, 1 = ACB stereo.
- l, r  out  16 each  signed PCM, left/right; feeds the I2S serializer.
- valid  out  1  one-clock pulse when l/r have been updated.

REQ-002 SHALL have one clock (clock); reset is synchronous and active-high (reset).

Function
REQ-003 SHALL use the states IDLE, S0, S1, S2, S3 and SAT.
- Transitions: IDLE->S0 on ce, then S0->S1->S2->S3->SAT->IDLE unconditionally.
REQ-004 In IDLE with ce=1, SHALL snapshot spk, ear, mic, a, b, c and stereo into internal registers.
- In the same clock, SHALL load both 18-bit signed accumulators (accL, accR) with -16384.
REQ-005 S0 SHALL add the beeper term to both accumulators.
- Beeper term = spk*8192 + ear*4096 + mic*2048.
REQ-006 S1, S2 and S3 SHALL add channels A, B and C respectively; the channel weight is level<<6 (range 0..16320).
REQ-007 Mono (stereo=0): every channel SHALL add its full weight to both accumulators.
REQ-008 ACB (stereo=1) SHALL apply these weights:
- A: full to L, half (>>1) to R.
- B: full to L and R.
- C: half to L, full to R.
REQ-009 SAT SHALL clamp each accumulator to [-32768, 32767], load the results into l and r, and set valid=1.
REQ-010 Latency: ce sampled at edge k SHALL update l, r and valid at edge k+5.
- valid SHALL be high for exactly the one clock following edge k+5.
REQ-011 ce asserted outside IDLE SHALL be ignored: no queueing, no restart, no effect on the current sample.
- ce at the edge where SAT completes SHALL also be ignored; only ce sampled in IDLE is accepted.
REQ-012 Input changes after the snapshot SHALL NOT affect the sample in progress.
REQ-013 l and r SHALL hold their last value between updates.

Reset
REQ-014 At reset, SHALL set: state=IDLE, l=0, r=0, valid=0, accumulators=0, snapshot registers=0.
REQ-015 Reset asserted mid-sequence SHALL abort it: no valid pulse, and l/r SHALL read 0 on the next clock.
REQ-016 reset SHALL take priority over ce in the same clock.

Configuration
REQ-017 Macro MIXER_DC_BLOCK_EN, when defined:
- SHALL add a state DC between SAT and IDLE.
- Per channel: out = sat - avg, where avg is a 16-bit signed register updated as avg += (sat - avg)>>>8.
- out SHALL be clamped to 16-bit signed.
- Latency becomes k+6; valid SHALL move to the DC cycle.
- avg SHALL reset to 0.
REQ-018 Without MIXER_DC_BLOCK_EN, the design SHALL have no DC state and no avg registers, and behaviour is exactly REQ-003..REQ-016.

Structure
REQ-019 Package audio_pkg SHALL hold:
- the state enumeration;
- ACC_W=18, BEEP_SPK=8192, BEEP_EAR=4096, BEEP_MIC=2048;
- AY_SHIFT=6, DC_OFFSET=-16384, DC_SHIFT=8.
REQ-020 The DC filter SHALL be a sub-module, mixer_dc_block, instantiated once per channel under MIXER_DC_BLOCK_EN.
REQ-021 The saturation SHALL be a package function shared by SAT and mixer_dc_block.

Verification (macro undefined unless stated)
REQ-022 All inputs 0, stereo=0, ce pulse -> l=r=16'hC000 five edges later, valid high one clock.
REQ-023 spk=1 only, mono -> l=r=16'hE000; then spk=ear=mic=1, a=b=c=255, mono -> l=r=16'h7FFF (saturated from 46912).
REQ-024 stereo=1, a=255, others 0 -> l=16'hFFC0, r=16'hDFE0.
REQ-025 ce pulses at k and k+2 -> exactly one valid, at k+5; ce at k+5 is ignored; ce at k+6 is accepted.
REQ-026 Reset asserted at k+3 after ce at k -> no valid pulse, l=r=0; the next ce is processed normally.
REQ-027 MIXER_DC_BLOCK_EN defined, constant inputs spk=1 mono, 2000 samples -> l and r decay monotonically toward 0, ending within ±64; valid at k+6.
